// File: rtl/imem_access_arbiter.sv
// Arbitrates one single-port instruction memory between CPU fetch and a loader/debug port.
// Optional macro IMEM_RANGE_CHECK_EN flags addresses beyond the array instead of aliasing.
module imem_access_arbiter #(
    parameter int unsigned DEPTH_LOG2   = 6,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  f_req_valid,
    output logic                  f_req_ready,
    input  logic [31:0]           f_addr,
    output logic                  f_rsp_valid,
    output logic [31:0]           f_rsp_data,
    output logic                  f_rsp_err,
    input  logic                  ld_req_valid,
    output logic                  ld_req_ready,
    input  logic                  ld_we,
    input  logic [31:0]           ld_addr,
    input  logic [31:0]           ld_wdata,
    input  logic                  ld_lock,
    output logic                  ld_rsp_valid,
    output logic [31:0]           ld_rsp_data,
    output logic                  ld_rsp_err,
    output logic                  lock_active,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic {StArb, StLocked} state_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    state_e      state_q;
    logic [3:0]  starve_cnt_q;
    logic        f_pend_q;
    logic        ld_pend_q;
    logic        err_q;
    logic        rd_q;

    logic        f_hs;
    logic        ld_hs;
    logic        any_hs;
    logic [31:0] sel_addr;
    logic        addr_bad;
    logic        unused_upper;

    always_comb begin
        f_req_ready  = 1'b0;
        ld_req_ready = 1'b0;
        if (state_q == StLocked) begin
            ld_req_ready = ld_req_valid;
        end else if (ld_req_valid && (!f_req_valid || starve_cnt_q == StarveMax)) begin
            ld_req_ready = 1'b1;
        end else begin
            f_req_ready = f_req_valid;
        end
    end

    assign f_hs     = f_req_valid & f_req_ready;
    assign ld_hs    = ld_req_valid & ld_req_ready;
    assign any_hs   = f_hs | ld_hs;
    assign sel_addr = ld_hs ? ld_addr : f_addr;

`ifdef IMEM_RANGE_CHECK_EN
    assign addr_bad = (|sel_addr[1:0]) | (|sel_addr[31:DEPTH_LOG2+2]);
`else
    assign addr_bad = |sel_addr[1:0];
`endif
    // Upper bits only matter when the range check is compiled in.
    assign unused_upper = ^sel_addr[31:DEPTH_LOG2+2];

    // A bad address still completes the handshake but never touches the array.
    assign mem_en    = any_hs & ~addr_bad;
    assign mem_we    = mem_en & ld_hs & ld_we;
    assign mem_addr  = sel_addr[DEPTH_LOG2+1:2];
    assign mem_wdata = ld_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StArb;
            starve_cnt_q <= 4'd0;
            f_pend_q     <= 1'b0;
            ld_pend_q    <= 1'b0;
            err_q        <= 1'b0;
            rd_q         <= 1'b0;
        end else begin
            f_pend_q  <= f_hs;
            ld_pend_q <= ld_hs;
            err_q     <= any_hs & addr_bad;
            rd_q      <= mem_en & ~mem_we;

            if (!ld_req_valid || ld_req_ready) begin
                starve_cnt_q <= 4'd0;
            end else if (starve_cnt_q != StarveMax) begin
                starve_cnt_q <= starve_cnt_q + 4'd1;
            end

            case (state_q)
                StArb:    if (ld_lock)  state_q <= StLocked;
                StLocked: if (!ld_lock) state_q <= StArb;
                default:  state_q <= StArb;
            endcase
        end
    end

    assign lock_active  = (state_q == StLocked);
    assign f_rsp_valid  = f_pend_q;
    assign f_rsp_err    = f_pend_q & err_q;
    assign f_rsp_data   = (f_pend_q & rd_q) ? mem_rdata : 32'd0;
    assign ld_rsp_valid = ld_pend_q;
    assign ld_rsp_err   = ld_pend_q & err_q;
    assign ld_rsp_data  = (ld_pend_q & rd_q) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed bench for imem_access_arbiter with a behavioural 64-word synchronous memory.
module tb_imem_access_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req_valid, f_req_ready;
    logic [31:0] f_addr;
    logic        f_rsp_valid, f_rsp_err;
    logic [31:0] f_rsp_data;
    logic        ld_req_valid, ld_req_ready, ld_we, ld_lock;
    logic [31:0] ld_addr, ld_wdata;
    logic        ld_rsp_valid, ld_rsp_err;
    logic [31:0] ld_rsp_data;
    logic        lock_active;
    logic        mem_en, mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic        load_init;
    logic [31:0] mem_q [64];
    int          n_total = 0;
    int          n_bad   = 0;

    imem_access_arbiter #(.DEPTH_LOG2(6), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_addr(f_addr),
        .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data), .f_rsp_err(f_rsp_err),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_lock(ld_lock),
        .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data), .ld_rsp_err(ld_rsp_err),
        .lock_active(lock_active), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    always @(posedge clk) begin
        if (load_init) begin
            for (int i = 0; i < 64; i++) mem_q[i] <= init_word(i);
        end else if (mem_en) begin
            if (mem_we) mem_q[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_q[mem_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_ld;
        rst_n = 1'b0; load_init = 1'b1; mem_rdata = 32'd0;
        f_req_valid = 1'b0; f_addr = 32'd0;
        ld_req_valid = 1'b0; ld_we = 1'b0; ld_addr = 32'd0; ld_wdata = 32'd0; ld_lock = 1'b0;
        step(); step();
        load_init = 1'b0;
        rst_n = 1'b1;
        #1;
        check_eq("rst_lock", 32'(lock_active), 32'd0);
        check_eq("rst_f_rsp_valid", 32'(f_rsp_valid), 32'd0);
        check_eq("rst_ld_rsp_valid", 32'(ld_rsp_valid), 32'd0);
        check_eq("rst_f_rsp_data", f_rsp_data, 32'd0);
        check_eq("rst_starve", 32'(dut.starve_cnt_q), 32'd0);
        check_eq("rst_mem_en", 32'(mem_en), 32'd0);
        step();

        // Fetch-only, back to back.
        for (int k = 0; k < 3; k++) begin
            f_req_valid = 1'b1; f_addr = 32'(k * 4);
            #1;
            check_eq($sformatf("fo_ready%0d", k), 32'(f_req_ready), 32'd1);
            check_eq($sformatf("fo_mem_en%0d", k), 32'(mem_en), 32'd1);
            check_eq($sformatf("fo_mem_we%0d", k), 32'(mem_we), 32'd0);
            check_eq($sformatf("fo_mem_addr%0d", k), 32'(mem_addr), 32'(k));
            step();
            check_eq($sformatf("fo_rsp_valid%0d", k), 32'(f_rsp_valid), 32'd1);
            check_eq($sformatf("fo_rsp_data%0d", k), f_rsp_data, init_word(k));
            check_eq($sformatf("fo_rsp_err%0d", k), 32'(f_rsp_err), 32'd0);
        end
        f_req_valid = 1'b0;
        step();
        check_eq("fo_idle_rsp", 32'(f_rsp_valid), 32'd0);

        // Contention: fetch 4 cycles, loader on the 5th, repeating.
        f_req_valid = 1'b1; f_addr = 32'h4;
        ld_req_valid = 1'b1; ld_we = 1'b0; ld_addr = 32'h20;
        for (int c = 0; c < 10; c++) begin
            #1;
            exp_ld = (c % 5 == 4);
            check_eq($sformatf("ct_starve%0d", c), 32'(dut.starve_cnt_q), 32'(c % 5));
            check_eq($sformatf("ct_ld_ready%0d", c), 32'(ld_req_ready), 32'(exp_ld));
            check_eq($sformatf("ct_f_ready%0d", c), 32'(f_req_ready), 32'(!exp_ld));
            check_eq($sformatf("ct_f_rsp%0d", c), 32'(f_rsp_valid), 32'(c > 0 && c % 5 != 0));
            check_eq($sformatf("ct_ld_rsp%0d", c), 32'(ld_rsp_valid), 32'(c == 5));
            if (c == 5) check_eq("ct_ld_data", ld_rsp_data, init_word(8));
            step();
        end
        f_req_valid = 1'b0; ld_req_valid = 1'b0;
        check_eq("ct_ld_rsp_last", 32'(ld_rsp_valid), 32'd1);
        check_eq("ct_ld_data_last", ld_rsp_data, init_word(8));
        step();

        // Lock entry with a fetch handshake in the same cycle, then a locked write.
        f_req_valid = 1'b1; f_addr = 32'h0;
        ld_req_valid = 1'b1; ld_we = 1'b1; ld_addr = 32'h10; ld_wdata = 32'hDEAD_BEEF;
        ld_lock = 1'b1;
        #1;
        check_eq("lk_entry_f_ready", 32'(f_req_ready), 32'd1);
        check_eq("lk_entry_ld_ready", 32'(ld_req_ready), 32'd0);
        check_eq("lk_entry_lock", 32'(lock_active), 32'd0);
        step();
        f_addr = 32'h10;
        check_eq("lk_lock_active", 32'(lock_active), 32'd1);
        check_eq("lk_f_rsp_valid", 32'(f_rsp_valid), 32'd1);
        check_eq("lk_f_rsp_data", f_rsp_data, init_word(0));
        #1;
        check_eq("lk_f_ready", 32'(f_req_ready), 32'd0);
        check_eq("lk_ld_ready", 32'(ld_req_ready), 32'd1);
        check_eq("lk_mem_we", 32'(mem_we), 32'd1);
        check_eq("lk_mem_addr", 32'(mem_addr), 32'd4);
        step();
        ld_req_valid = 1'b0; ld_lock = 1'b0;
        check_eq("lk_wr_rsp_valid", 32'(ld_rsp_valid), 32'd1);
        check_eq("lk_wr_rsp_data", ld_rsp_data, 32'd0);
        check_eq("lk_wr_rsp_err", 32'(ld_rsp_err), 32'd0);
        #1;
        check_eq("lk_exit_f_ready", 32'(f_req_ready), 32'd0);
        step();
        check_eq("lk_exit_lock", 32'(lock_active), 32'd0);
        #1;
        check_eq("lk_post_f_ready", 32'(f_req_ready), 32'd1);
        step();
        f_req_valid = 1'b0;
        check_eq("lk_readback", f_rsp_data, 32'hDEAD_BEEF);

        // Misaligned fetch and loader write.
        f_req_valid = 1'b1; f_addr = 32'h6;
        #1;
        check_eq("ma_f_ready", 32'(f_req_ready), 32'd1);
        check_eq("ma_f_mem_en", 32'(mem_en), 32'd0);
        step();
        f_req_valid = 1'b0;
        check_eq("ma_f_rsp_valid", 32'(f_rsp_valid), 32'd1);
        check_eq("ma_f_rsp_err", 32'(f_rsp_err), 32'd1);
        check_eq("ma_f_rsp_data", f_rsp_data, 32'd0);
        ld_req_valid = 1'b1; ld_we = 1'b1; ld_addr = 32'h13; ld_wdata = 32'h1234_5678;
        #1;
        check_eq("ma_ld_ready", 32'(ld_req_ready), 32'd1);
        check_eq("ma_ld_mem_en", 32'(mem_en), 32'd0);
        check_eq("ma_ld_mem_we", 32'(mem_we), 32'd0);
        step();
        check_eq("ma_ld_rsp_valid", 32'(ld_rsp_valid), 32'd1);
        check_eq("ma_ld_rsp_err", 32'(ld_rsp_err), 32'd1);
        ld_we = 1'b0; ld_addr = 32'h10;
        step();
        ld_req_valid = 1'b0;
        check_eq("ma_ld_readback", ld_rsp_data, 32'hDEAD_BEEF);
        check_eq("ma_ld_readback_err", 32'(ld_rsp_err), 32'd0);

        // Out-of-range fetch.
        f_req_valid = 1'b1; f_addr = 32'h100;
        #1;
`ifdef IMEM_RANGE_CHECK_EN
        check_eq("rg_mem_en", 32'(mem_en), 32'd0);
`else
        check_eq("rg_mem_en", 32'(mem_en), 32'd1);
`endif
        step();
        f_req_valid = 1'b0;
        check_eq("rg_rsp_valid", 32'(f_rsp_valid), 32'd1);
`ifdef IMEM_RANGE_CHECK_EN
        check_eq("rg_rsp_err", 32'(f_rsp_err), 32'd1);
        check_eq("rg_rsp_data", f_rsp_data, 32'd0);
`else
        check_eq("rg_rsp_err", 32'(f_rsp_err), 32'd0);
        check_eq("rg_rsp_data", f_rsp_data, init_word(0));
`endif

        // Reset right after a fetch handshake that also entered lock with the loader waiting.
        f_req_valid = 1'b1; f_addr = 32'h8;
        ld_req_valid = 1'b1; ld_we = 1'b0; ld_addr = 32'h0; ld_lock = 1'b1;
        step();
        check_eq("rm_pre_lock", 32'(lock_active), 32'd1);
        check_eq("rm_pre_starve", 32'(dut.starve_cnt_q), 32'd1);
        rst_n = 1'b0;
        f_req_valid = 1'b0; ld_req_valid = 1'b0; ld_lock = 1'b0;
        #1;
        check_eq("rm_f_rsp_valid", 32'(f_rsp_valid), 32'd0);
        check_eq("rm_lock", 32'(lock_active), 32'd0);
        check_eq("rm_starve", 32'(dut.starve_cnt_q), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        check_eq("rm_post_f_rsp", 32'(f_rsp_valid), 32'd0);
        check_eq("rm_post_ld_rsp", 32'(ld_rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_access_arbiter.md
Name: imem_access_arbiter

Overview:
- Shares one single-port synchronous instruction memory (64 x 32-bit words by default) between two requesters: the CPU fetch port (read-only) and a loader/debug port (read/write).
- Fetch has fixed priority. A starvation counter guarantees forward progress for the loader.
- A lock mode lets the loader own the memory exclusively for a program load.
- Sits between the fetch stage/PC logic and the instruction memory array.

Parameters:
- DEPTH_LOG2, 6, memory word-index width (64 words); the word index is addr[DEPTH_LOG2+1:2].
- STARVE_LIMIT, 4, consecutive cycles the loader waits with ld_req_valid high before it wins over fetch; range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- f_req_valid  in  1  fetch request
- f_req_ready  out  1  fetch granted this cycle (combinational)
- f_addr  in  32  fetch byte address
- f_rsp_valid  out  1  fetch response pulse, 1 cycle after handshake
- f_rsp_data  out  32  fetched instruction, valid with f_rsp_valid
- f_rsp_err  out  1  fetch error, valid with f_rsp_valid
- ld_req_valid  in  1  loader request
- ld_req_ready  out  1  loader granted this cycle (combinational)
- ld_we  in  1  1 = write, 0 = read
- ld_addr  in  32  loader byte address
- ld_wdata  in  32  write data
- ld_lock  in  1  request exclusive ownership
- ld_rsp_valid  out  1  loader response pulse
- ld_rsp_data  out  32  read data (0 for writes)
- ld_rsp_err  out  1  loader error
- lock_active  out  1  high while in LOCKED state
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  DEPTH_LOG2  word index
- mem_wdata  out  32  write data to memory
- mem_rdata  in  32  memory read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active-low.
- Reset values: state=ARB, starve_cnt=0, and f_rsp_valid, ld_rsp_valid, f_rsp_err, ld_rsp_err, lock_active all 0.
  - Data outputs are forced to 0 while their valid is 0.
  - Reset asserted mid-operation drops any in-flight response; no pulse is produced after reset release.
- States:
  - ARB: normal arbitration.
  - LOCKED: loader only.
  - Transitions are evaluated at the clock edge. ARB->LOCKED when ld_lock=1; LOCKED->ARB when ld_lock=0.
  - lock_active = (state==LOCKED).
- Grant in ARB (combinational, same cycle):
  - Loader wins when ld_req_valid && (!f_req_valid || starve_cnt==STARVE_LIMIT).
  - Otherwise fetch wins if f_req_valid.
  - Exactly one ready is high at most, and only when its valid is high.
- Grant in LOCKED: f_req_ready=0 always; ld_req_ready=ld_req_valid.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, each cycle ld_req_valid=1 and ld_req_ready=0.
  - Clears when the loader is granted or ld_req_valid=0.
- Handshake: transfer occurs when valid && ready.
  - Requester inputs are sampled only in the handshake cycle.
  - Both ports may issue back-to-back, one transfer per cycle total.
- Memory drive in the handshake cycle: mem_en=1, mem_addr=addr[DEPTH_LOG2+1:2], mem_we=ld_we (loader) or 0 (fetch), mem_wdata=ld_wdata.
  - No handshake: mem_en=0, mem_we=0.
- Response: exactly one cycle after the handshake, the granted port's rsp_valid pulses high for one cycle.
  - rsp_data = mem_rdata for reads, 0 for writes.
  - There is no response backpressure; requesters must accept.
- Misaligned address (addr[1:0]!=0):
  - Handshake still completes, but mem_en=0 (the write is suppressed).
  - Next cycle rsp_valid=1, rsp_err=1, rsp_data=0.
- Address bits above DEPTH_LOG2+1 are ignored (aliasing) unless the optional feature is enabled.
- Lock entry with a fetch handshake in the same cycle: the fetch completes normally, and its response arrives in the first LOCKED cycle.

Optional Feature:
- Macro: IMEM_RANGE_CHECK_EN.
- Defined: any request with addr[31:DEPTH_LOG2+2]!=0 is treated like a misaligned access: no memory access, rsp_err=1, rsp_data=0.
- Not defined: upper address bits are ignored and addresses alias into the array; rsp_err reflects misalignment only.

Test Plan:
- Reset, then fetch only: f_addr=0x0,0x4,0x8 on consecutive cycles -> f_req_ready=1 every cycle; f_rsp_data = mem words 0,1,2 one cycle later; mem_we=0.
- Contention: both valid continuously, STARVE_LIMIT=4 -> fetch granted 4 cycles, loader granted on the 5th cycle, starve_cnt returns to 0, pattern repeats.
- Lock load: ld_lock=1, loader writes 0xDEADBEEF to 0x10 -> lock_active=1 next cycle; f_req_ready=0 throughout; then ld_lock=0 and fetch 0x10 -> f_rsp_data=0xDEADBEEF.
- Misaligned: fetch 0x6 -> mem_en=0; next cycle f_rsp_valid=1, f_rsp_err=1, f_rsp_data=0. Loader write to 0x13 leaves memory unchanged.
- Range: fetch 0x100 -> with IMEM_RANGE_CHECK_EN, f_rsp_err=1; without it, returns word 0 with no error.
- Reset mid-flight: assert rst_n=0 in the cycle after a fetch handshake -> f_rsp_valid stays 0, lock_active=0, starve_cnt=0.
